// File: rtl/flash_read_channel_if.sv
// rtl/flash_read_channel_if.sv - flash read channel bus bundle (masters, flash controller, status)
interface flash_read_channel_if #(
    parameter int ADDR_SZ = 16
);
    logic               i_emib_rd_irq;
    logic [ADDR_SZ-1:0] i_emib_addr_offset;
    logic [ADDR_SZ-1:0] i_emib_data_len;
    logic               o_emib_wr_en;
    logic [ADDR_SZ-1:0] o_emib_waddr;
    logic [15:0]        o_emib_data;
    logic               o_emib_rd_dn;

    logic               i_dpram_rd_irq;
    logic [ADDR_SZ-1:0] i_dpram_addr_offset;
    logic [ADDR_SZ-1:0] i_dpram_data_len;
    logic               o_dpram_wr_en;
    logic [ADDR_SZ-1:0] o_dpram_waddr;
    logic [15:0]        o_dpram_data;
    logic               o_dpram_rd_dn;

    logic               o_flash_rd_irq;
    logic [ADDR_SZ-1:0] o_flash_addr_offset;
    logic [ADDR_SZ-1:0] o_flash_data_len;
    logic               i_flash_rd_en;
    logic [ADDR_SZ-1:0] i_flash_raddr;
    logic [15:0]        i_flash_data;
    logic               i_rd_dn;

    logic               o_busy;
    logic               o_rd_err;

    modport slave (
        input  i_emib_rd_irq, i_emib_addr_offset, i_emib_data_len,
        output o_emib_wr_en, o_emib_waddr, o_emib_data, o_emib_rd_dn,
        input  i_dpram_rd_irq, i_dpram_addr_offset, i_dpram_data_len,
        output o_dpram_wr_en, o_dpram_waddr, o_dpram_data, o_dpram_rd_dn,
        output o_flash_rd_irq, o_flash_addr_offset, o_flash_data_len,
        input  i_flash_rd_en, i_flash_raddr, i_flash_data, i_rd_dn,
        output o_busy, o_rd_err
    );

    modport master (
        output i_emib_rd_irq, i_emib_addr_offset, i_emib_data_len,
        input  o_emib_wr_en, o_emib_waddr, o_emib_data, o_emib_rd_dn,
        output i_dpram_rd_irq, i_dpram_addr_offset, i_dpram_data_len,
        input  o_dpram_wr_en, o_dpram_waddr, o_dpram_data, o_dpram_rd_dn,
        input  o_flash_rd_irq, o_flash_addr_offset, o_flash_data_len,
        output i_flash_rd_en, i_flash_raddr, i_flash_data, i_rd_dn,
        input  o_busy, o_rd_err
    );
endinterface

// File: rtl/flash_read_channel.sv
// rtl/flash_read_channel.sv - EMIB/DPRAM flash read arbiter and word router; FLASH_RD_TIMEOUT_EN adds an XFER idle abort
module flash_read_channel #(
    parameter int ADDR_SZ     = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    flash_read_channel_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    state_t             state, state_nxt;
    logic               sel;            // 0 = EMIB, 1 = DPRAM
    logic               pend_emib, pend_dpram;
    logic [ADDR_SZ-1:0] word_cnt;
    logic               eff_emib, eff_dpram;
    logic               grant, grant_sel, issue, strobe, drop, tmo_hit;

    assign eff_emib  = pend_emib  | bus.i_emib_rd_irq;
    assign eff_dpram = pend_dpram | bus.i_dpram_rd_irq;
    assign bus.o_busy = (state != IDLE);

`ifdef FLASH_RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] tmo_cnt;

    // Counts idle XFER cycles; any delivered or dropped word restarts the window.
    always_ff @(posedge i_clk) begin
        if (i_rst || state != XFER || bus.i_flash_rd_en) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_sel = 1'b0;
        issue     = 1'b0;
        strobe    = 1'b0;
        drop      = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (eff_emib || eff_dpram) begin
                    grant     = 1'b1;
                    grant_sel = ~eff_emib;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.o_flash_data_len == '0) begin
                    state_nxt = DONE;
                end else begin
                    issue     = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (bus.i_flash_rd_en) begin
                    if (word_cnt < bus.o_flash_data_len) begin
                        strobe = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (bus.i_rd_dn) begin
                    state_nxt = DONE;
                end
`ifdef FLASH_RD_TIMEOUT_EN
                else if (!bus.i_flash_rd_en && tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = DONE;
                end
`endif
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sel                     <= 1'b0;
            pend_emib               <= 1'b0;
            pend_dpram              <= 1'b0;
            word_cnt                <= '0;
            bus.o_flash_rd_irq      <= 1'b0;
            bus.o_flash_addr_offset <= '0;
            bus.o_flash_data_len    <= '0;
            bus.o_emib_wr_en        <= 1'b0;
            bus.o_emib_waddr        <= '0;
            bus.o_emib_data         <= '0;
            bus.o_emib_rd_dn        <= 1'b0;
            bus.o_dpram_wr_en       <= 1'b0;
            bus.o_dpram_waddr       <= '0;
            bus.o_dpram_data        <= '0;
            bus.o_dpram_rd_dn       <= 1'b0;
            bus.o_rd_err            <= 1'b0;
        end else begin
            // A request that arrives while its own master is served stays pending for a later pass.
            pend_emib  <= eff_emib  & ~(grant & ~grant_sel);
            pend_dpram <= eff_dpram & ~(grant &  grant_sel);

            if (grant) begin
                sel                     <= grant_sel;
                word_cnt                <= '0;
                bus.o_flash_addr_offset <= grant_sel ? bus.i_dpram_addr_offset : bus.i_emib_addr_offset;
                bus.o_flash_data_len    <= grant_sel ? bus.i_dpram_data_len    : bus.i_emib_data_len;
            end else if (state == DONE) begin
                bus.o_flash_addr_offset <= '0;
                bus.o_flash_data_len    <= '0;
            end else if (strobe) begin
                word_cnt <= word_cnt + 1'b1;
            end

            bus.o_flash_rd_irq <= issue;
            bus.o_rd_err       <= drop | tmo_hit;

            bus.o_emib_wr_en   <= strobe & ~sel;
            bus.o_emib_waddr   <= (strobe & ~sel) ? bus.i_flash_raddr : '0;
            bus.o_emib_data    <= (strobe & ~sel) ? bus.i_flash_data  : '0;
            bus.o_emib_rd_dn   <= (state == DONE) & ~sel;

            bus.o_dpram_wr_en  <= strobe & sel;
            bus.o_dpram_waddr  <= (strobe & sel) ? bus.i_flash_raddr : '0;
            bus.o_dpram_data   <= (strobe & sel) ? bus.i_flash_data  : '0;
            bus.o_dpram_rd_dn  <= (state == DONE) & sel;
        end
    end
endmodule

// File: tb/tb_flash_read_channel.sv
// tb/tb_flash_read_channel.sv - directed self-checking bench for flash_read_channel
module tb_flash_read_channel;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    flash_read_channel_if #(.ADDR_SZ(16)) bus ();

    flash_read_channel #(.ADDR_SZ(16), .TIMEOUT_CYC(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_emib_quiet(input string tag);
        check({tag, " emib_wr_en"}, 32'(bus.o_emib_wr_en), 0);
        check({tag, " emib_waddr"}, 32'(bus.o_emib_waddr), 0);
        check({tag, " emib_data"},  32'(bus.o_emib_data),  0);
        check({tag, " emib_rd_dn"}, 32'(bus.o_emib_rd_dn), 0);
    endtask

    task automatic check_dpram_quiet(input string tag);
        check({tag, " dpram_wr_en"}, 32'(bus.o_dpram_wr_en), 0);
        check({tag, " dpram_waddr"}, 32'(bus.o_dpram_waddr), 0);
        check({tag, " dpram_data"},  32'(bus.o_dpram_data),  0);
        check({tag, " dpram_rd_dn"}, 32'(bus.o_dpram_rd_dn), 0);
    endtask

    task automatic req(input logic emib, input logic dpram,
                       input logic [15:0] e_off, input logic [15:0] e_len,
                       input logic [15:0] d_off, input logic [15:0] d_len);
        bus.i_emib_rd_irq       = emib;
        bus.i_emib_addr_offset  = e_off;
        bus.i_emib_data_len     = e_len;
        bus.i_dpram_rd_irq      = dpram;
        bus.i_dpram_addr_offset = d_off;
        bus.i_dpram_data_len    = d_len;
        step();
        bus.i_emib_rd_irq  = 1'b0;
        bus.i_dpram_rd_irq = 1'b0;
    endtask

    task automatic word(input logic [15:0] raddr, input logic [15:0] data);
        bus.i_flash_rd_en = 1'b1;
        bus.i_flash_raddr = raddr;
        bus.i_flash_data  = data;
        step();
        bus.i_flash_rd_en = 1'b0;
        bus.i_flash_raddr = '0;
        bus.i_flash_data  = '0;
    endtask

    task automatic finish_xfer();
        bus.i_rd_dn = 1'b1;
        step();
        bus.i_rd_dn = 1'b0;
    endtask

    initial begin
        bus.i_emib_rd_irq = 0; bus.i_emib_addr_offset = 0; bus.i_emib_data_len = 0;
        bus.i_dpram_rd_irq = 0; bus.i_dpram_addr_offset = 0; bus.i_dpram_data_len = 0;
        bus.i_flash_rd_en = 0; bus.i_flash_raddr = 0; bus.i_flash_data = 0; bus.i_rd_dn = 0;

        step(); step();
        check("reset busy", 32'(bus.o_busy), 0);
        check("reset flash_irq", 32'(bus.o_flash_rd_irq), 0);
        check("reset flash_len", 32'(bus.o_flash_data_len), 0);
        check("reset rd_err", 32'(bus.o_rd_err), 0);
        check_emib_quiet("reset");
        check_dpram_quiet("reset");
        rst = 1'b0;

        // EMIB read, offset 0x0100, 4 words
        req(1, 0, 16'h0100, 16'd4, 0, 0);
        check("t1 busy after grant", 32'(bus.o_busy), 1);
        check("t1 irq not yet", 32'(bus.o_flash_rd_irq), 0);
        step();
        check("t1 flash_irq", 32'(bus.o_flash_rd_irq), 1);
        check("t1 flash_off", 32'(bus.o_flash_addr_offset), 32'h0100);
        check("t1 flash_len", 32'(bus.o_flash_data_len), 4);
        for (int i = 0; i < 4; i++) begin
            word(16'(i), 16'hA000 + 16'(i));
            check("t1 flash_irq one cycle", 32'(bus.o_flash_rd_irq), 0);
            check("t1 emib_wr_en", 32'(bus.o_emib_wr_en), 1);
            check("t1 emib_waddr", 32'(bus.o_emib_waddr), i);
            check("t1 emib_data", 32'(bus.o_emib_data), 32'hA000 + i);
            check_dpram_quiet("t1");
        end
        finish_xfer();
        check("t1 wr_en idle", 32'(bus.o_emib_wr_en), 0);
        check("t1 rd_dn early", 32'(bus.o_emib_rd_dn), 0);
        step();
        check("t1 emib_rd_dn", 32'(bus.o_emib_rd_dn), 1);
        check("t1 flash_len cleared", 32'(bus.o_flash_data_len), 0);
        check("t1 busy done", 32'(bus.o_busy), 0);
        check_dpram_quiet("t1 done");
        step();
        check("t1 rd_dn one cycle", 32'(bus.o_emib_rd_dn), 0);

        // Simultaneous EMIB and DPRAM requests: EMIB first, DPRAM follows
        req(1, 1, 16'h0010, 16'd2, 16'h0020, 16'd2);
        step();
        check("t2 emib flash_off", 32'(bus.o_flash_addr_offset), 32'h0010);
        check("t2 emib irq", 32'(bus.o_flash_rd_irq), 1);
        word(0, 16'hB000);
        check("t2 emib w0", 32'(bus.o_emib_data), 32'hB000);
        word(1, 16'hB001);
        check("t2 emib w1 addr", 32'(bus.o_emib_waddr), 1);
        check_dpram_quiet("t2 emib phase");
        finish_xfer();
        step();
        check("t2 emib_rd_dn", 32'(bus.o_emib_rd_dn), 1);
        check("t2 dpram_rd_dn not yet", 32'(bus.o_dpram_rd_dn), 0);
        step();
        check("t2 dpram granted", 32'(bus.o_busy), 1);
        step();
        check("t2 dpram irq", 32'(bus.o_flash_rd_irq), 1);
        check("t2 dpram flash_off", 32'(bus.o_flash_addr_offset), 32'h0020);
        word(0, 16'hD000);
        check("t2 dpram_wr_en", 32'(bus.o_dpram_wr_en), 1);
        check("t2 dpram_data", 32'(bus.o_dpram_data), 32'hD000);
        word(1, 16'hD001);
        check("t2 dpram_waddr", 32'(bus.o_dpram_waddr), 1);
        check_emib_quiet("t2 dpram phase");
        finish_xfer();
        step();
        check("t2 dpram_rd_dn", 32'(bus.o_dpram_rd_dn), 1);
        check("t2 emib no second dn", 32'(bus.o_emib_rd_dn), 0);
        step();
        check("t2 idle", 32'(bus.o_busy), 0);

        // DPRAM zero-length read
        req(0, 1, 0, 0, 16'h0040, 16'd0);
        step();
        check("t3 no flash_irq", 32'(bus.o_flash_rd_irq), 0);
        check("t3 dn not yet", 32'(bus.o_dpram_rd_dn), 0);
        step();
        check("t3 dpram_rd_dn", 32'(bus.o_dpram_rd_dn), 1);
        check("t3 flash_irq still 0", 32'(bus.o_flash_rd_irq), 0);
        step();
        check("t3 idle", 32'(bus.o_busy), 0);

        // DPRAM len 2 with an overflow word
        req(0, 1, 0, 0, 16'h0050, 16'd2);
        step();
        check("t4 irq", 32'(bus.o_flash_rd_irq), 1);
        word(0, 16'h1111);
        check("t4 w0", 32'(bus.o_dpram_wr_en), 1);
        check("t4 w0 err", 32'(bus.o_rd_err), 0);
        word(1, 16'h2222);
        check("t4 w1 data", 32'(bus.o_dpram_data), 32'h2222);
        word(2, 16'h3333);
        check("t4 w2 dropped", 32'(bus.o_dpram_wr_en), 0);
        check("t4 w2 data 0", 32'(bus.o_dpram_data), 0);
        check("t4 rd_err", 32'(bus.o_rd_err), 1);
        finish_xfer();
        check("t4 rd_err one cycle", 32'(bus.o_rd_err), 0);
        step();
        check("t4 dpram_rd_dn", 32'(bus.o_dpram_rd_dn), 1);
        step();

        // Reset mid-transfer
        req(1, 0, 16'h0200, 16'd4, 0, 0);
        step();
        word(0, 16'hEEEE);
        check("t5 first word", 32'(bus.o_emib_wr_en), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5 busy", 32'(bus.o_busy), 0);
        check("t5 flash_off", 32'(bus.o_flash_addr_offset), 0);
        check("t5 flash_len", 32'(bus.o_flash_data_len), 0);
        check_emib_quiet("t5 rst");
        check_dpram_quiet("t5 rst");
        finish_xfer();
        check("t5 stray rd_dn busy", 32'(bus.o_busy), 0);
        step();
        check("t5 no emib_rd_dn", 32'(bus.o_emib_rd_dn), 0);
        req(0, 1, 0, 0, 16'h0030, 16'd1);
        step();
        check("t5 new irq", 32'(bus.o_flash_rd_irq), 1);
        check("t5 new off", 32'(bus.o_flash_addr_offset), 32'h0030);
        word(0, 16'hC0DE);
        check("t5 new data", 32'(bus.o_dpram_data), 32'hC0DE);
        finish_xfer();
        step();
        check("t5 new rd_dn", 32'(bus.o_dpram_rd_dn), 1);
        step();

`ifdef FLASH_RD_TIMEOUT_EN
        // No words after the read command: abort after 16 idle XFER cycles
        req(1, 0, 16'h0300, 16'd2, 0, 0);
        step();
        check("t6 irq", 32'(bus.o_flash_rd_irq), 1);
        for (int k = 1; k < 16; k++) begin
            step();
            check("t6 no early err", 32'(bus.o_rd_err), 0);
        end
        step();
        check("t6 rd_err", 32'(bus.o_rd_err), 1);
        step();
        check("t6 emib_rd_dn", 32'(bus.o_emib_rd_dn), 1);
        check("t6 busy", 32'(bus.o_busy), 0);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
